// File: rtl/gpio_pattern_gen_if.sv
// rtl/gpio_pattern_gen_if.sv - control/status bundle for the GPIO pattern generator
//
// Purpose: groups the configuration handshake, run controls and GPIO outputs
// of gpio_pattern_gen so they pass as a single port.
// Signals:
//   cfg_valid/cfg_ready      configuration handshake (accepted when both high)
//   cfg_mode/cfg_dir/cfg_div pattern mode, direction, update period - 1
//   burst_len                updates per run, 0 = infinite
//   start/pause/stop/step    single-cycle run controls
//   gpio                     NCH banks of WIDTH bits, bank k at [k*WIDTH +: WIDTH]
//   tick/done/busy           update pulse, burst-complete pulse, not-idle flag
// Modports: master drives controls (bench / host), slave is the generator.

interface gpio_pattern_gen_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2,
    parameter int DIV_W = 24,
    parameter int CNT_W = 16
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [1:0]             cfg_mode;
    logic                   cfg_dir;
    logic [DIV_W-1:0]       cfg_div;
    logic [CNT_W-1:0]       burst_len;
    logic                   start;
    logic                   pause;
    logic                   stop;
    logic                   step;
    logic [NCH*WIDTH-1:0]   gpio;
    logic                   tick;
    logic                   done;
    logic                   busy;

    modport master (
        output cfg_valid, cfg_mode, cfg_dir, cfg_div, burst_len,
        output start, pause, stop, step,
        input  cfg_ready, gpio, tick, done, busy
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_dir, cfg_div, burst_len,
        input  start, pause, stop, step,
        output cfg_ready, gpio, tick, done, busy
    );
endinterface

// File: rtl/gpio_pattern_gen.sv
// rtl/gpio_pattern_gen.sv - prescaled GPIO pattern generator with burst/pause/step
//
// Purpose: drives NCH banks of WIDTH-bit GPIO with walk-0, walk-1, count or
// toggle patterns, one update every cfg_div+1 clocks while running. Bank k is
// the pattern rotated left by (k*CH_SKEW) mod WIDTH.
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-high
//   bus   gpio_pattern_gen_if.slave (config handshake, run controls, gpio, status)

module gpio_pattern_gen #(
    parameter int WIDTH    = 32,
    parameter int NCH      = 2,
    parameter int CH_SKEW  = 8,
    parameter int DIV_W    = 24,
    parameter int CNT_W    = 16,
    parameter int MODE_RST = 0,
    parameter int DIV_RST  = 3
) (
    input  logic                clk,
    input  logic                rst,
    gpio_pattern_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         mode_q;
    logic               dir_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   presc_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [WIDTH-1:0]   pattern_q, next_pat;
    logic               tick_q, done_q;

    logic               cfg_take;
    logic               do_update;
    logic               last_update;
    logic               run_load;
    logic               ctr_clr;
    logic               presc_inc;
    logic [NCH*WIDTH-1:0] gpio_w;

    function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m);
        logic [WIDTH-1:0] s;
        s = '0;
        case (m)
            2'b00:   s = ~WIDTH'(1);
            2'b01:   s = WIDTH'(1);
            2'b10:   s = '0;
            default: for (int i = 0; i < WIDTH; i++) s[i] = (i % 2 == 0);
        endcase
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] p, input int sh);
        logic [2*WIDTH-1:0] d;
        d = {p, p} << sh;
        return d[2*WIDTH-1:WIDTH];
    endfunction

    assign cfg_take = (state == S_IDLE) && bus.cfg_valid;

    // Control priority is stop > pause > start > step; a control action in
    // RUN suppresses that cycle's prescaler update.
    always_comb begin
        state_nxt   = state;
        do_update   = 1'b0;
        run_load    = 1'b0;
        ctr_clr     = 1'b0;
        presc_inc   = 1'b0;
        last_update = 1'b0;
        case (state)
            S_IDLE: begin
                // A config offered together with start wins and keeps us idle.
                if (bus.start && !bus.cfg_valid) begin
                    state_nxt = S_RUN;
                    run_load  = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_nxt = S_IDLE;
                    ctr_clr   = 1'b1;
                end else if (bus.pause) begin
                    state_nxt = S_HOLD;
                end else if (presc_q == div_q) begin
                    do_update = 1'b1;
                end else begin
                    presc_inc = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.stop) begin
                    state_nxt = S_IDLE;
                    ctr_clr   = 1'b1;
                end else if (bus.pause) begin
                    state_nxt = S_HOLD;
                end else if (bus.start) begin
                    state_nxt = S_RUN;
                end else if (bus.step) begin
                    do_update = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                ctr_clr   = 1'b1;
            end
        endcase
        last_update = do_update && (remaining_q == CNT_W'(1));
        if (last_update) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        next_pat = pattern_q;
        case (mode_q)
            2'b00, 2'b01: next_pat = dir_q ? {pattern_q[0], pattern_q[WIDTH-1:1]}
                                           : {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
            2'b10:        next_pat = dir_q ? pattern_q - WIDTH'(1) : pattern_q + WIDTH'(1);
            default:      next_pat = ~pattern_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= 2'(MODE_RST);
            dir_q       <= 1'b0;
            div_q       <= DIV_W'(DIV_RST);
            pattern_q   <= seed_of(2'(MODE_RST));
            presc_q     <= '0;
            remaining_q <= '0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            tick_q <= do_update;
            done_q <= last_update;

            if (cfg_take) begin
                mode_q    <= bus.cfg_mode;
                dir_q     <= bus.cfg_dir;
                div_q     <= bus.cfg_div;
                pattern_q <= seed_of(bus.cfg_mode);
            end else if (do_update) begin
                pattern_q <= next_pat;
            end

            // Steps taken in HOLD leave the prescaler where pause froze it.
            if (run_load || ctr_clr || (do_update && state == S_RUN)) begin
                presc_q <= '0;
            end else if (presc_inc) begin
                presc_q <= presc_q + DIV_W'(1);
            end

            if (run_load) begin
                remaining_q <= bus.burst_len;
            end else if (ctr_clr) begin
                remaining_q <= '0;
            end else if (do_update && remaining_q != '0) begin
                remaining_q <= remaining_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        gpio_w = '0;
        for (int k = 0; k < NCH; k++) begin
            gpio_w[k*WIDTH +: WIDTH] = rotl(pattern_q, (k * CH_SKEW) % WIDTH);
        end
    end

    assign bus.gpio      = gpio_w;
    assign bus.tick      = tick_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.cfg_ready = (state == S_IDLE);

endmodule
